// File: rtl/reg8_arb_pkg.sv
// Shared types and helpers for the reg8_arb round-robin register arbiter.
// Optional write counter is enabled with the REG8_ARB_WCNT_EN macro.
package reg8_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] WCNT_MAX = 8'd255;

  // Both operands are already below n, so a single conditional subtract wraps.
  function automatic int wrapAdd(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/reg8_arb_rr_pick.sv
// Rotated first-one search: returns the first set request at or after ptr,
// wrapping modulo N. Purely combinational so other arbiters can reuse it.
module rr_pick
  import reg8_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan from the farthest candidate back to ptr so the closest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[wrapAdd(int'(ptr), k, N)]) begin
        found = 1'b1;
        idx   = IW'(wrapAdd(int'(ptr), k, N));
      end
    end
  end

endmodule

// File: rtl/reg8_arb.sv
// Round-robin write arbiter for a shared W-bit register with 4-phase req/ack.
// Define REG8_ARB_WCNT_EN to add the saturating wr_cnt write counter output.
module reg8_arb
  import reg8_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*W-1:0]  din,
  output logic [N-1:0]    ack,
  output logic [W-1:0]    q,
  output logic [IW-1:0]   gnt_id,
`ifdef REG8_ARB_WCNT_EN
  output logic [7:0]      wr_cnt,
`endif
  output logic            busy
);

  state_t        state_q;
  logic [W-1:0]  q_q, q_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [IW-1:0] gnt_q;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          busy_q;
  logic          pickFound;
  logic [IW-1:0] pickIdx;

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) uPick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pickFound),
    .idx   (pickIdx)
  );

  // Everything the WRITE state commits is derived from the held grant index.
  always_comb begin
    q_d   = '0;
    ack_d = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_q == IW'(i)) begin
        q_d      = din[i*W +: W];
        ack_d[i] = 1'b1;
      end
    end
    ptr_d = IW'(wrapAdd(int'(gnt_q), 1, N));
  end

`ifdef REG8_ARB_WCNT_EN
  logic [7:0] wcnt_q, wcnt_d;

  assign wcnt_d = (wcnt_q == WCNT_MAX) ? wcnt_q : wcnt_q + 8'd1;
  assign wr_cnt = wcnt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      ack_q   <= '0;
      gnt_q   <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
`ifdef REG8_ARB_WCNT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pickFound) begin
            gnt_q   <= pickIdx;
            busy_q  <= 1'b1;
            state_q <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          q_q     <= q_d;
          ack_q   <= ack_d;
          ptr_q   <= ptr_d;
          state_q <= ST_WAIT;
`ifdef REG8_ARB_WCNT_EN
          wcnt_q  <= wcnt_d;
`endif
        end
        ST_WAIT: begin
          // Only the granted requester can close the handshake.
          if (!req[gnt_q]) begin
            ack_q   <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack    = ack_q;
  assign q      = q_q;
  assign gnt_id = gnt_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_reg8_arb.sv
// Self-checking bench for reg8_arb: transaction-level reference model compared
// every cycle, plus directed literal checks. Define REG8_ARB_WCNT_EN to test wr_cnt.
module tb_reg8_arb;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int IW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   ack;
  logic [W-1:0]   q;
  logic [IW-1:0]  gnt_id;
  logic           busy;
`ifdef REG8_ARB_WCNT_EN
  logic [7:0]     wr_cnt;
`endif

  int tests = 0;
  int fails = 0;

  reg8_arb #(
    .N  (N),
    .W  (W),
    .IW (IW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .din    (din),
    .ack    (ack),
    .q      (q),
    .gnt_id (gnt_id),
`ifdef REG8_ARB_WCNT_EN
    .wr_cnt (wr_cnt),
`endif
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = waiting for a request, 1 = granted, 2 = acknowledged.
  int mPhase = 0;
  int mGnt   = 0;
  int mPtr   = 0;
  int mQ     = 0;
  int mWcnt  = 0;

  always @(posedge clk or negedge rst) begin : model
    int k;
    if (!rst) begin
      mPhase <= 0;
      mGnt   <= 0;
      mPtr   <= 0;
      mQ     <= 0;
      mWcnt  <= 0;
    end else begin
      case (mPhase)
        0: begin
          if (req != '0) begin
            k = 0;
            while (!req[(mPtr + k) % N]) k++;
            mGnt   <= (mPtr + k) % N;
            mPhase <= 1;
          end
        end
        1: begin
          mQ     <= int'(din[mGnt*W +: W]);
          mPtr   <= (mGnt + 1) % N;
          mWcnt  <= (mWcnt < 255) ? mWcnt + 1 : 255;
          mPhase <= 2;
        end
        default: begin
          if (!req[mGnt]) mPhase <= 0;
        end
      endcase
    end
  end

  int logIdx[$];
  int logQ[$];
  logic [N-1:0] prevAckMon = '0;

  // Per-cycle comparison against the model, plus a log of every new acknowledge.
  always @(negedge clk) begin : compare
    int expAck;
    expAck = (mPhase == 2) ? (1 << mGnt) : 0;
    checkOutput("q", int'(q), mQ);
    checkOutput("ack", int'(ack), expAck);
    checkOutput("gnt_id", int'(gnt_id), mGnt);
    checkOutput("busy", int'(busy), (mPhase != 0) ? 1 : 0);
`ifdef REG8_ARB_WCNT_EN
    checkOutput("wr_cnt", int'(wr_cnt), mWcnt);
`endif
    if ((ack & ~prevAckMon) != '0) begin
      for (int i = 0; i < N; i++) if (ack[i]) logIdx.push_back(i);
      logQ.push_back(int'(q));
    end
    prevAckMon = ack;
  end

  // Producers: drop req on ack, re-raise when allowed; random mode also churns data.
  task automatic applyStimulus(input logic [N-1:0] mask, input int nAcks,
                               input int maxCycles, input bit randomMode);
    int seen = 0;
    int cyc = 0;
    logic [N-1:0] prevAck = ack;
    while (seen < nAcks && cyc < maxCycles) begin
      @(negedge clk);
      cyc++;
      if ((ack & ~prevAck) != '0) seen++;
      prevAck = ack;
      if (randomMode) din = $urandom;
      for (int i = 0; i < N; i++) begin
        if (ack[i]) req[i] = 1'b0;
        else if (!randomMode) req[i] = mask[i];
        else if (!req[i]) req[i] = mask[i] && ($urandom_range(2) == 0);
        else if ($urandom_range(15) == 0) req[i] = 1'b0;
      end
    end
    checkOutput("producer_acks", seen, nAcks);
  endtask

  task automatic drainIdle();
    req = '0;
    for (int c = 0; c < 10 && (busy || ack != '0); c++) @(negedge clk);
    checkOutput("drain_idle", int'(busy), 0);
  endtask

  task automatic waitAck(input int maxCycles);
    for (int c = 0; c < maxCycles && ack == '0; c++) @(negedge clk);
    checkOutput("ack_seen", (ack != '0) ? 1 : 0, 1);
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst = 1'b0;
    req = '0;
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int expIdx[6];
    int expQ[6];
    int cnt;
    expIdx = '{0, 1, 3, 0, 1, 3};
    expQ   = '{8'h01, 8'h02, 8'h08, 8'h01, 8'h02, 8'h08};

    // Reset held with every request asserted.
    rst = 1'b1;
    req = '0;
    din = '0;
    #1 rst = 1'b0;
    req = 4'b1111;
    #25;
    checkOutput("rst_q", int'(q), 0);
    checkOutput("rst_ack", int'(ack), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_gnt", int'(gnt_id), 0);
    @(negedge clk);
    rst = 1'b1;
    waitAck(10);
    checkOutput("first_ack", int'(ack), 4'b0001);
    checkOutput("first_gnt", int'(gnt_id), 0);
    drainIdle();

    // Single requester: grant edge, then data and ack one edge later.
    @(negedge clk);
    din = '0;
    din[2*W +: W] = 8'h99;
    req = 4'b0100;
    @(negedge clk);
    checkOutput("single_busy", int'(busy), 1);
    checkOutput("single_ack_pre", int'(ack), 0);
    checkOutput("single_gnt", int'(gnt_id), 2);
    @(negedge clk);
    checkOutput("single_ack", int'(ack), 4'b0100);
    checkOutput("single_q", int'(q), 8'h99);
    req = '0;
    @(negedge clk);
    checkOutput("single_ack_drop", int'(ack), 0);
    checkOutput("single_idle", int'(busy), 0);

    // Round-robin over 1011 starting from ptr 0.
    doReset();
    din = 32'h08040201;
    logIdx.delete();
    logQ.delete();
    applyStimulus(4'b1011, 6, 200, 1'b0);
    drainIdle();
    #1;
    checkOutput("rr_count", logIdx.size(), 6);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("rr_idx%0d", i), (i < logIdx.size()) ? logIdx[i] : -1, expIdx[i]);
      checkOutput($sformatf("rr_q%0d", i), (i < logQ.size()) ? logQ[i] : -1, expQ[i]);
    end
    foreach (logIdx[i]) if (logIdx[i] == 2) cnt++;
    checkOutput("rr_no_idx2", cnt, 0);

    // Wrap and simultaneity: ptr is back at 0 after serving index 3.
    logIdx.delete();
    logQ.delete();
    applyStimulus(4'b1001, 2, 100, 1'b0);
    drainIdle();
    #1;
    checkOutput("wrap_first", (logIdx.size() > 0) ? logIdx[0] : -1, 0);
    checkOutput("wrap_second", (logIdx.size() > 1) ? logIdx[1] : -1, 3);

    // Asynchronous reset while waiting in the acknowledge phase.
    @(negedge clk);
    din = '0;
    din[1*W +: W] = 8'h55;
    req = 4'b0010;
    waitAck(10);
    checkOutput("midrst_q_before", int'(q), 8'h55);
    #2 rst = 1'b0;
    #1;
    checkOutput("midrst_q", int'(q), 0);
    checkOutput("midrst_ack", int'(ack), 0);
    checkOutput("midrst_busy", int'(busy), 0);
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_idle", int'(busy), 0);

    // Randomized traffic, including drops before acknowledge.
    for (int r = 0; r < 6; r++) begin
      applyStimulus(4'($urandom_range(1, 15)), 15, 1500, 1'b1);
      drainIdle();
    end

`ifdef REG8_ARB_WCNT_EN
    doReset();
    din = 32'h44332211;
    applyStimulus(4'b1111, 260, 4000, 1'b0);
    drainIdle();
    checkOutput("wcnt_sat", int'(wr_cnt), 255);
    applyStimulus(4'b0101, 2, 100, 1'b0);
    drainIdle();
    checkOutput("wcnt_hold", int'(wr_cnt), 255);
    doReset();
    checkOutput("wcnt_rst", int'(wr_cnt), 0);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/reg8_arb.md
Name: reg8_arb

Overview:
- Round-robin write arbiter for a shared W-bit register. Up to N requesters each present data plus a 4-phase req/ack handshake.
- The block grants one requester at a time, loads that requester's data into the held register, and acknowledges the write.
- It sits between several producer FSMs and one shared register/output bus.

Parameters:
- N, 4, number of requesters (2..8)
- W, 8, data/register width
- IW, 2, grant index width; must satisfy 2**IW >= N

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-low reset
- req  input  N  request per requester; held high until matching ack seen
- din  input  N*W  flattened data; requester i occupies din[i*W +: W]
- ack  output  N  one-hot acknowledge; high while the write is being completed
- q  output  W  shared register contents
- gnt_id  output  IW  index of current/last granted requester
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async, immediate): state=IDLE, q=0, ack=0, gnt_id=0, ptr=0, busy=0. Reset mid-operation aborts the transaction; no partial write survives.
- States: IDLE, WRITE, WAIT. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, searching ptr, ptr+1, ... wrapping modulo N.
  - gnt_id<=i, state<=WRITE.
- WRITE (one cycle):
  - q<=din[gnt_id] (data is sampled at this edge, not at the grant edge).
  - ack[gnt_id]<=1.
  - ptr<=(gnt_id+1) mod N.
  - state<=WAIT.
- WAIT:
  - Hold ack.
  - When req[gnt_id]==0: ack<=0, state<=IDLE.
  - Other requests are ignored until IDLE.
- Latency: req rises before edge k → q valid and ack high after edge k+1. After req falls, ack falls at the next edge. Minimum back-to-back spacing is 3 cycles per write.
- Fairness:
  - ptr advances past the winner, so every continuously asserting requester is served within N grants.
  - Simultaneous requests resolve purely by ptr order.
- Wrap-around: the ptr increment from N-1 returns to 0. If N is not a power of two, indices >= N are never produced.
- Requester dropping req while in WRITE: the write still completes, ack asserts for 1 cycle, then the block returns to IDLE.
- Requests for unselected indices raised during WRITE/WAIT stay pending; they are not lost.
- busy = (state!=IDLE).
- q holds its value between writes.

Optional Feature:
- Macro: REG8_ARB_WCNT_EN
- Defined: adds output wr_cnt[7:0].
  - Reset to 0.
  - Increments once per WRITE state.
  - Saturates at 255 (no wrap).
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Decomposition:
- Shared include file (reg8_arb_defs.vh):
  - state encodings ST_IDLE=2'd0, ST_WRITE=2'd1, ST_WAIT=2'd2
  - counter saturation constant WCNT_MAX=8'd255
- Sub-module rr_pick (combinational): inputs req[N], ptr[IW]; outputs found and idx[IW]. It implements the rotated first-one search and is reused by future arbiters.

Test Plan:
- Reset: hold rst=0 for 25 ns with req=4'b1111 → q=8'h00, ack=0, busy=0, gnt_id=0. Release → first grant goes to index 0.
- Single requester: req[2]=1 with din[2]=8'h99.
  - q=8'h99 and ack=4'b0100 one cycle after the grant edge.
  - Drop req[2] → ack=0 next edge, busy=0.
- Round-robin: hold req=4'b1011 with distinct data 8'h01/8'h02/8'h08.
  - Grant order is 0,1,3,0,1,3.
  - Index 2 is never acked.
  - q sequence matches the data in that order.
- Wrap and simultaneity: after serving index 3, assert req=4'b1001 in the same cycle → index 0 wins; the next grant goes to index 3.
- Reset mid-operation: assert rst=0 while in WAIT with q=8'h55 → q=0 and ack=0 immediately (async, before the next clk). After release the block is in IDLE.
- With REG8_ARB_WCNT_EN defined: perform 260 writes → wr_cnt=255 and stays at 255. Reset → wr_cnt=0.
